// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
// Shared types and constants for the LED panel frame buffer.
//   rgb_t          : packed 3-bit pixel, r at bit 0, g at bit 1, b at bit 2
//   DEF_ROWS/COLS  : default panel geometry
//   RGB_*_IDX      : serial bit order inside a pixel (R first, then G, then B)
//   fb_wr_state_t  : serial write FSM states
// -----------------------------------------------------------------------------
package led_panel_pkg;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 16;

  localparam int RGB_R_IDX = 0;
  localparam int RGB_G_IDX = 1;
  localparam int RGB_B_IDX = 2;

  typedef struct packed {
    logic b;
    logic g;
    logic r;
  } rgb_t;

  typedef enum logic [1:0] {
    FB_WR_IDLE = 2'd0,
    FB_WR_LOAD = 2'd1,
    FB_WR_HOLD = 2'd2
  } fb_wr_state_t;

endpackage

// File: rtl/led_fb_serial_rx.sv
// -----------------------------------------------------------------------------
// led_fb_serial_rx
// Three-wire serial pixel receiver. Assembles R,G,B bits into a pixel, walks
// the write pointer across the frame and issues one write per pixel.
//
// Ports:
//   clk, reset       : clock, asynchronous active-low reset
//   sdata_i          : serial data bit, sampled when sstb_i is high
//   sstb_i           : data strobe
//   sframe_i         : frame start; clears pointer and bit counter
//   wr_en_o          : pixel commit this cycle (same edge as the third strobe)
//   wr_row_o/wr_col_o: commit address
//   wr_rgb_o         : committed pixel {B,G,R}
//   frame_last_o     : the commit this cycle is the last pixel of the frame
//   frame_abort_o    : frame start arrived while a frame was being loaded
// -----------------------------------------------------------------------------
module led_fb_serial_rx
  import led_panel_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 3,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdata_i,
  input  logic             sstb_i,
  input  logic             sframe_i,
  output logic             wr_en_o,
  output logic [ROW_W-1:0] wr_row_o,
  output logic [COL_W-1:0] wr_col_o,
  output logic [2:0]       wr_rgb_o,
  output logic             frame_last_o,
  output logic             frame_abort_o
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

  fb_wr_state_t     state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       shift_q, shift_d;   // holds R and G until B arrives
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  rgb_t             px;

  // The third bit is taken straight from the input so the pixel commits on
  // the same edge that samples it.
  always_comb begin
    px                       = '0;
    px.r                     = shift_q[RGB_R_IDX];
    px.g                     = shift_q[RGB_G_IDX];
    px.b                     = sdata_i;
  end

  assign wr_rgb_o = px;
  assign wr_row_o = row_q;
  assign wr_col_o = col_q;

  // NOTE: every signal driven here gets a default first; a path that left one
  // unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    row_d         = row_q;
    col_d         = col_q;
    wr_en_o       = 1'b0;
    frame_last_o  = 1'b0;
    frame_abort_o = 1'b0;

    if (sframe_i) begin
      // Frame start has priority; a coincident strobe is dropped.
      state_d       = FB_WR_LOAD;
      cnt_d         = 2'd0;
      row_d         = '0;
      col_d         = '0;
      frame_abort_o = (state_q == FB_WR_LOAD);
    end else if (sstb_i && (state_q == FB_WR_LOAD)) begin
      unique case (cnt_q)
        2'd0: begin
          shift_d[RGB_R_IDX] = sdata_i;
          cnt_d              = 2'd1;
        end
        2'd1: begin
          shift_d[RGB_G_IDX] = sdata_i;
          cnt_d              = 2'd2;
        end
        default: begin
          wr_en_o = 1'b1;
          cnt_d   = 2'd0;
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d        = '0;
              frame_last_o = 1'b1;
              state_d      = FB_WR_HOLD;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FB_WR_IDLE;
      cnt_q   <= 2'd0;
      shift_q <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

endmodule

// File: rtl/led_panel_framebuf.sv
// -----------------------------------------------------------------------------
// led_panel_framebuf
// Pixel frame buffer feeding led_panel_single. Pixels arrive over a three-wire
// serial port and are read back by row/column with one cycle of latency.
//
// Build option LED_FRAMEBUF_DBUF_EN:
//   defined   : front/back buffers; writes go to the back buffer, reads come
//               from the front, and the swap follows frame_done_in once a
//               complete frame is pending.
//   undefined : single buffer; commits are visible immediately, frame_done_in
//               is ignored and swap_pending_out is 0.
//
// Ports:
//   clk, reset          : panel clock, asynchronous active-low reset
//   sdata_in, sstb_in   : serial data bit and its strobe
//   sframe_in           : synchronous frame start
//   rd_row_in, rd_col_in: read address from the driver
//   rd_rgb_out          : registered pixel {B,G,R}; 0 for out-of-range address
//   frame_done_in       : end-of-scan pulse from the driver
//   wr_frame_done_out   : one-cycle pulse after the last pixel commits
//   swap_pending_out    : a complete back frame awaits a swap
// -----------------------------------------------------------------------------
module led_panel_framebuf
  import led_panel_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int ROW_W = 3,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sdata_in,
  input  logic             sstb_in,
  input  logic             sframe_in,
  input  logic [ROW_W-1:0] rd_row_in,
  input  logic [COL_W-1:0] rd_col_in,
  output logic [2:0]       rd_rgb_out,
  input  logic             frame_done_in,
  output logic             wr_frame_done_out,
  output logic             swap_pending_out
);

`ifdef LED_FRAMEBUF_DBUF_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  // Index widths that exactly cover the array; address ports may be wider.
  localparam int RI_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CI_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ROW_W:0] ROWS_LIM = (ROW_W + 1)'(ROWS);
  localparam logic [COL_W:0] COLS_LIM = (COL_W + 1)'(COLS);

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_col;
  logic [2:0]       wr_rgb;
  logic             frame_last;
  logic             frame_abort;

  logic             wr_buf;
  logic             rd_buf;
  logic [2:0]       mem_q [NBUF][ROWS][COLS];
  logic [2:0]       rd_rgb_q, rd_rgb_d;
  logic             wr_done_q;
  logic             rd_in_range;

  led_fb_serial_rx #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_rx (
    .clk           (clk),
    .reset         (reset),
    .sdata_i       (sdata_in),
    .sstb_i        (sstb_in),
    .sframe_i      (sframe_in),
    .wr_en_o       (wr_en),
    .wr_row_o      (wr_row),
    .wr_col_o      (wr_col),
    .wr_rgb_o      (wr_rgb),
    .frame_last_o  (frame_last),
    .frame_abort_o (frame_abort)
  );

`ifdef LED_FRAMEBUF_DBUF_EN
  logic front_sel_q, front_sel_d;
  logic swap_pending_q, swap_pending_d;

  // The swap looks only at the registered pending flag, so a frame finishing
  // in the same cycle as frame_done_in waits for the next end-of-scan.
  always_comb begin
    front_sel_d    = front_sel_q;
    swap_pending_d = swap_pending_q;
    if (frame_done_in && swap_pending_q) begin
      front_sel_d    = ~front_sel_q;
      swap_pending_d = 1'b0;
    end
    if (frame_abort) begin
      swap_pending_d = 1'b0;
    end
    if (frame_last) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      front_sel_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      front_sel_q    <= front_sel_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign wr_buf           = ~front_sel_q;
  assign rd_buf           = front_sel_q;
  assign swap_pending_out = swap_pending_q;
`else
  logic unused_dbuf;

  assign wr_buf           = 1'b0;
  assign rd_buf           = 1'b0;
  assign swap_pending_out = 1'b0;
  assign unused_dbuf      = frame_done_in ^ frame_abort;
`endif

  // Write addresses never exceed the array, so bits above the index width
  // are always zero.
  logic unused_wr_addr;
  assign unused_wr_addr = ^{wr_row, wr_col};

  // NOTE: the pixel store is reset explicitly because the panel must show
  // black after reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBUF; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            mem_q[b][r][c] <= 3'b000;
          end
        end
      end
    end else if (wr_en) begin
      mem_q[wr_buf][wr_row[RI_W-1:0]][wr_col[CI_W-1:0]] <= wr_rgb;
    end
  end

  assign rd_in_range = ({1'b0, rd_row_in} < ROWS_LIM) && ({1'b0, rd_col_in} < COLS_LIM);

  always_comb begin
    rd_rgb_d = 3'b000;
    if (rd_in_range) begin
      rd_rgb_d = mem_q[rd_buf][rd_row_in[RI_W-1:0]][rd_col_in[CI_W-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_rgb_q  <= 3'b000;
      wr_done_q <= 1'b0;
    end else begin
      rd_rgb_q  <= rd_rgb_d;
      wr_done_q <= frame_last;
    end
  end

  assign rd_rgb_out        = rd_rgb_q;
  assign wr_frame_done_out = wr_done_q;

endmodule

// File: tb/tb_led_panel_framebuf.sv
// -----------------------------------------------------------------------------
// tb_led_panel_framebuf
// Directed bench for led_panel_framebuf. Expected values are hand-derived;
// where the single- and double-buffer builds differ, the expectation follows
// LED_FRAMEBUF_DBUF_EN. A 4-bit row port is used so out-of-range rows can be
// addressed.
// -----------------------------------------------------------------------------
module tb_led_panel_framebuf;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;

`ifdef LED_FRAMEBUF_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic             sdata_in;
  logic             sstb_in;
  logic             sframe_in;
  logic [ROW_W-1:0] rd_row_in;
  logic [COL_W-1:0] rd_col_in;
  logic [2:0]       rd_rgb_out;
  logic             frame_done_in;
  logic             wr_frame_done_out;
  logic             swap_pending_out;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  led_panel_framebuf #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .sdata_in          (sdata_in),
    .sstb_in           (sstb_in),
    .sframe_in         (sframe_in),
    .rd_row_in         (rd_row_in),
    .rd_col_in         (rd_col_in),
    .rd_rgb_out        (rd_rgb_out),
    .frame_done_in     (frame_done_in),
    .wr_frame_done_out (wr_frame_done_out),
    .swap_pending_out  (swap_pending_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (wr_frame_done_out === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic d, input logic fd);
    sstb_in       = 1'b1;
    sdata_in      = d;
    frame_done_in = fd;
    step();
    sstb_in       = 1'b0;
    sdata_in      = 1'b0;
    frame_done_in = 1'b0;
  endtask

  task automatic send_pixel(input logic [2:0] v, input logic fd_last);
    strobe(v[0], 1'b0);
    strobe(v[1], 1'b0);
    strobe(v[2], fd_last);
  endtask

  task automatic sframe_pulse();
    sframe_in = 1'b1;
    step();
    sframe_in = 1'b0;
  endtask

  task automatic pulse_fd();
    frame_done_in = 1'b1;
    step();
    frame_done_in = 1'b0;
  endtask

  // Pixel k of the frame carries (k + off) % 8.
  task automatic send_frame(input int off, input logic fd_last);
    logic [2:0] v;
    for (int k = 0; k < ROWS * COLS; k++) begin
      v = 3'((k + off) % 8);
      send_pixel(v, fd_last && (k == ROWS * COLS - 1));
    end
  endtask

  task automatic check_px(input string tag, input int r, input int c, input logic [2:0] exp);
    rd_row_in = ROW_W'(r);
    rd_col_in = COL_W'(c);
    step();
    check(tag, {29'd0, rd_rgb_out}, {29'd0, exp});
  endtask

  initial begin
    reset         = 1'b0;
    sdata_in      = 1'b0;
    sstb_in       = 1'b0;
    sframe_in     = 1'b0;
    frame_done_in = 1'b0;
    rd_row_in     = '0;
    rd_col_in     = '0;

    // Power-on reset
    step();
    step();
    check("por_rgb", {29'd0, rd_rgb_out}, 32'd0);
    check("por_done", {31'd0, wr_frame_done_out}, 32'd0);
    check("por_pending", {31'd0, swap_pending_out}, 32'd0);
    reset = 1'b1;
    step();
    check_px("por_mem_0_0", 0, 0, 3'b000);
    check_px("por_mem_7_15", 7, 15, 3'b000);

    // Reset asserted mid-LOAD clears outputs, storage and FSM
    sframe_pulse();
    for (int k = 0; k < 5; k++) send_pixel(3'b111, 1'b0);
    strobe(1'b1, 1'b0);
    rd_row_in = '0;
    rd_col_in = '0;
    step();
    #3 reset = 1'b0;
    #1;
    check("mid_rst_rgb", {29'd0, rd_rgb_out}, 32'd0);
    check("mid_rst_done", {31'd0, wr_frame_done_out}, 32'd0);
    check("mid_rst_pending", {31'd0, swap_pending_out}, 32'd0);
    step();
    step();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) check_px("mid_rst_mem", 0, c, 3'b000);
    // Back in IDLE: strobes without a frame start are ignored
    send_pixel(3'b111, 1'b0);
    check_px("idle_ignore_0_0", 0, 0, 3'b000);
    check_px("idle_ignore_0_1", 0, 1, 3'b000);

    // Full frame, pixel k = k % 8
    sframe_pulse();
    send_frame(0, 1'b0);
    check("f1_done_pulse", {31'd0, wr_frame_done_out}, 32'd1);
    check("f1_pending", {31'd0, swap_pending_out}, {31'd0, DBUF});
    check_px("f1_preswap_2_5", 2, 5, DBUF ? 3'd0 : 3'd5);
    check("f1_done_low", {31'd0, wr_frame_done_out}, 32'd0);
    check("f1_done_cnt", done_cnt, 32'd1);
    pulse_fd();
    check("f1_pending_clr", {31'd0, swap_pending_out}, 32'd0);
    check_px("f1_swap_2_5", 2, 5, 3'd5);
    check_px("f1_swap_7_15", 7, 15, 3'd7);
    check_px("f1_swap_0_3", 0, 3, 3'd3);

    // Strobes in HOLD are ignored; out-of-range rows read 0
    for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
    check("hold_done_low", {31'd0, wr_frame_done_out}, 32'd0);
    check_px("hold_0_0", 0, 0, 3'd0);
    check_px("hold_0_1", 0, 1, 3'd1);
    check("hold_done_cnt", done_cnt, 32'd1);
    check_px("oob_row9", 9, 3, 3'd0);
    check_px("oob_row8", 8, 5, 3'd0);

    // Last commit coincides with frame_done_in: swap waits for the next pulse
    sframe_pulse();
    send_frame(1, 1'b1);
    check("co_pending", {31'd0, swap_pending_out}, {31'd0, DBUF});
    check_px("co_noswap_2_5", 2, 5, DBUF ? 3'd5 : 3'd6);
    pulse_fd();
    check("co_pending_clr", {31'd0, swap_pending_out}, 32'd0);
    check_px("co_swap_2_5", 2, 5, 3'd6);
    check_px("co_swap_7_15", 7, 15, 3'd0);
    check("co_done_cnt", done_cnt, 32'd2);

    // Restart after two bits of pixel 7 with a coincident strobe
    sframe_pulse();
    for (int k = 0; k < 7; k++) send_pixel(3'b010, 1'b0);
    strobe(1'b1, 1'b0);
    strobe(1'b1, 1'b0);
    sframe_in = 1'b1;
    sstb_in   = 1'b1;
    sdata_in  = 1'b1;
    step();
    sframe_in = 1'b0;
    sstb_in   = 1'b0;
    sdata_in  = 1'b0;
    send_pixel(3'b101, 1'b0);
    check_px("rs_imm_0_0", 0, 0, DBUF ? 3'b001 : 3'b101);
    for (int k = 1; k < ROWS * COLS; k++) send_pixel(3'(k % 8), 1'b0);
    check("rs_done_pulse", {31'd0, wr_frame_done_out}, 32'd1);
    check("rs_pending", {31'd0, swap_pending_out}, {31'd0, DBUF});
    pulse_fd();
    check_px("rs_0_0", 0, 0, 3'b101);
    check_px("rs_0_1", 0, 1, 3'd1);
    check_px("rs_0_7", 0, 7, 3'd7);
    check_px("rs_2_5", 2, 5, 3'd5);
    check("rs_done_cnt", done_cnt, 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_panel_framebuf.md
# led_panel_framebuf

Pixel frame buffer directly upstream of `led_panel_single`. It accepts pixel data over a three-wire serial write port driven from the spare chip inputs and serves 3-bit RGB pixels to the panel driver by row/column address. Double buffering presents only complete frames to the panel, with the buffer swap aligned to the driver's end-of-scan pulse. It shares the panel clock domain.

## Interface
Parameters:
- `ROWS`, 8, number of panel rows (max 8)
- `COLS`, 16, number of columns per row (max 16)
- `ROW_W`, 3, row address width
- `COL_W`, 4, column address width

Ports:
- `clk`  in  1  panel clock, the only clock
- `reset`  in  1  asynchronous, active-low reset
- `sdata_in`  in  1  serial pixel data bit
- `sstb_in`  in  1  strobe; `sdata_in` is sampled on the rising `clk` edge when high
- `sframe_in`  in  1  synchronous frame start; clears the write pointer and the bit counter
- `rd_row_in`  in  ROW_W  read row address from the driver
- `rd_col_in`  in  COL_W  read column address from the driver
- `rd_rgb_out`  out  3  registered pixel {B,G,R}, with bit 0 = red
- `frame_done_in`  in  1  one-cycle pulse from the driver after the last row is latched
- `wr_frame_done_out`  out  1  one-cycle pulse when the last pixel of a frame is committed
- `swap_pending_out`  out  1  high while a complete back frame is waiting to be swapped

## Operation
- **Bit assembly:** 3 strobes make one pixel, in order R, G, B. A 2-bit counter runs 0→1→2→0.
- **Pixel commit:** on the third strobe, the pixel is written to the write buffer at (wrow, wcol).
- **Write pointer:** after each commit, `wcol` increments. At `COLS-1` it wraps to 0 and `wrow` increments.
- **Frame complete:** committing pixel (`ROWS-1`, `COLS-1`) makes the frame complete:
  - pulse `wr_frame_done_out`;
  - set `swap_pending`;
  - enter HOLD, where further strobes are ignored until `sframe_in`.
- **Write FSM states:** IDLE → (`sframe_in`) LOAD → (last pixel committed) HOLD → (`sframe_in`) LOAD. Strobes are ignored in IDLE.
- **`sframe_in` and `sstb_in` in the same cycle:** `sframe_in` wins; the strobe is discarded.
- **`sframe_in` mid-frame:** the partial pixel and frame are discarded, the pointer and bit counter return to 0, and `swap_pending` is cleared. Partial back-buffer contents remain but are overwritten by the new frame.
- **Swap:** when `frame_done_in` is high and `swap_pending` is high (registered value), the front select toggles and `swap_pending` clears.
- **Frame completion and `frame_done_in` in the same cycle:** no swap that cycle. The swap occurs at the next `frame_done_in`.
- **Read:** `rd_rgb_out` ≤ front[rd_row_in][rd_col_in]. If `rd_row_in >= ROWS` or `rd_col_in >= COLS`, it reads 3'b000.
- **Reset:**
  - both buffers cleared to 0;
  - front select = 0, FSM = IDLE, pointer and bit counter = 0;
  - `rd_rgb_out` = 0, `wr_frame_done_out` = 0, `swap_pending_out` = 0.

## Timing
- **Read latency:** 1 cycle from address to `rd_rgb_out`.
- **Commit:** occurs on the edge that samples the third strobe. `wr_frame_done_out` is high for the cycle following that edge.
- **Swap:** takes effect on the edge sampling `frame_done_in`. The next-cycle read returns new-front data.
- **Strobe rate:** back-to-back strobes, one per cycle, are legal. A full frame takes a minimum of `3*ROWS*COLS` cycles.
- **`swap_pending_out`** is a registered flag, with no combinational path from inputs.

## Configuration
- `LED_FRAMEBUF_DBUF_EN` defined:
  - two buffers, front/back as described.
  - Writes always go to the back buffer; reads always come from the front buffer.
- `LED_FRAMEBUF_DBUF_EN` undefined:
  - single buffer; commits are immediately visible to reads, so tearing is allowed.
  - `frame_done_in` is ignored and `swap_pending_out` is tied 0.
  - `wr_frame_done_out` and HOLD behave unchanged.

## Structure
- **Package `led_panel_pkg`:**
  - `rgb_t` (packed 3-bit, fields r/g/b at bits 0/1/2);
  - default `ROWS`/`COLS`;
  - bit-order constants `RGB_R_IDX`, `RGB_G_IDX`, `RGB_B_IDX`;
  - write FSM state enum `fb_wr_state_t`.
- **Sub-module `led_fb_serial_rx`:** contains the bit counter, shift register, write pointer and FSM. It outputs `wr_en`, `wr_row`, `wr_col`, `wr_rgb` and `frame_last`.
- **Top level:** holds the storage, swap logic and read register.

## Test plan
- **Reset:** assert `reset`=0 mid-LOAD. Expect all outputs 0, reads of every address return 000, and the FSM back in IDLE.
- **Full frame with DBUF:** `sframe_in`, then 384 strobes with pixel k = k%8.
  - Before swap: `wr_frame_done_out` pulses once and `swap_pending_out`=1, but reads still return 000.
  - After `frame_done_in`: reads (2,5) = (2*16+5)%8 = 5.
- **Coincidence:** `frame_done_in` in the same cycle as the last commit → no swap. Swap happens at the following `frame_done_in`.
- **Restart:** `sframe_in` after 2 bits of pixel 7, with `sstb_in` also high. The strobe is discarded and the next 3 strobes land at (0,0).
- **Overflow:** 6 extra strobes in HOLD → no writes and pointer unchanged. `rd_row_in`=9 → 000.
- **Without DBUF:** a commit to (0,0)=3'b101 reads back 3'b101 two cycles after the third strobe, with no `frame_done_in` needed.
